// File: rtl/intersection_sequencer.sv
// Phase sequencer for a four-way intersection: self-timed tick, per-phase dwell,
// and an emergency override that forces and holds the all-red phases.
module intersection_sequencer #(
    parameter int CLKS_PER_TICK = 50000000,
    parameter int GREEN_TICKS   = 10,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALLRED_TICKS  = 2,
    parameter int LEFT_TICKS    = 5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       emergency,
    output logic [2:0] phase,
    output logic       tick,
    output logic [7:0] ticks_left,
    output logic       red_hold
);

    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALLRED_A  = 3'd2,
        PH_EW_LEFT   = 3'd3,
        PH_EW_GREEN  = 3'd4,
        PH_EW_YELLOW = 3'd5,
        PH_ALLRED_B  = 3'd6,
        PH_NS_LEFT   = 3'd7
    } phase_t;

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_TICK - 1);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_TICKS - 1);

    logic [PW-1:0] prescaler;
    phase_t        phase_q, phase_d;
    logic [7:0]    ticks_q, ticks_d;
    logic          red_hold_q, red_hold_d;

    // Dwell counter value loaded on entry to each phase.
    function automatic logic [7:0] dwell_load(input phase_t p);
        case (p)
            PH_NS_GREEN, PH_EW_GREEN:   dwell_load = 8'(GREEN_TICKS - 1);
            PH_NS_YELLOW, PH_EW_YELLOW: dwell_load = 8'(YELLOW_TICKS - 1);
            PH_ALLRED_A, PH_ALLRED_B:   dwell_load = ALLRED_LOAD;
            default:                    dwell_load = 8'(LEFT_TICKS - 1);
        endcase
    endfunction

    assign tick = (prescaler == PRE_LAST);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prescaler  <= '0;
            phase_q    <= PH_NS_GREEN;
            ticks_q    <= 8'(GREEN_TICKS - 1);
            red_hold_q <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + 1'b1;
            phase_q    <= phase_d;
            ticks_q    <= ticks_d;
            red_hold_q <= red_hold_d;
        end
    end

    phase_t seq_next;
    logic   step_normal;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        phase_d     = phase_q;
        ticks_d     = ticks_q;
        step_normal = 1'b0;
        seq_next    = phase_t'(phase_q + 3'd1);
        red_hold_d  = emergency && (phase_q == PH_ALLRED_A || phase_q == PH_ALLRED_B);

        if (tick) begin
            unique case (phase_q)
                PH_NS_GREEN, PH_EW_GREEN: begin
                    if (emergency) begin
                        phase_d = seq_next;
                        ticks_d = dwell_load(seq_next);
                    end else begin
                        step_normal = 1'b1;
                    end
                end
                PH_EW_LEFT, PH_NS_LEFT: begin
                    // Fall back to the preceding all-red; the left phase restarts later.
                    if (emergency) begin
                        phase_d = phase_t'(phase_q - 3'd1);
                        ticks_d = ALLRED_LOAD;
                    end else begin
                        step_normal = 1'b1;
                    end
                end
                PH_ALLRED_A, PH_ALLRED_B: begin
                    if (emergency) ticks_d = ALLRED_LOAD;
                    else           step_normal = 1'b1;
                end
                default: step_normal = 1'b1;
            endcase

            if (step_normal) begin
                if (ticks_q == 8'd0) begin
                    phase_d = seq_next;
                    ticks_d = dwell_load(seq_next);
                end else begin
                    ticks_d = ticks_q - 8'd1;
                end
            end
        end
    end

    assign phase      = phase_q;
    assign ticks_left = ticks_q;
    assign red_hold   = red_hold_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer with a 4-cycle tick and short dwells.
module tb_intersection_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       emergency;
    logic [2:0] phase;
    logic       tick;
    logic [7:0] ticks_left;
    logic       red_hold;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    intersection_sequencer #(
        .CLKS_PER_TICK(4),
        .GREEN_TICKS  (3),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1),
        .LEFT_TICKS   (2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .emergency (emergency),
        .phase     (phase),
        .tick      (tick),
        .ticks_left(ticks_left),
        .red_hold  (red_hold)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s @cycle %0d observed=%0d expected=%0d", tag, cyc, observed, expected);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the edge ending this cycle.
    task automatic next_cycle();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    // Leaves the bench in cycle 0: registers at reset values, reset low.
    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        emergency = 1'b0;
        reset     = 1'b1;

        // Free run
        do_reset();
        check("rst_phase", phase, 0);
        check("rst_ticks_left", ticks_left, 2);
        check("rst_red_hold", red_hold, 0);
        check("rst_tick", tick, 0);
        goto(2);  check("tick_c2_low", tick, 0);
        goto(3);  check("tick_c3", tick, 1);
        goto(4);  check("tl_c4", ticks_left, 1);
        goto(7);  check("tick_c7", tick, 1);
        goto(8);  check("tl_c8", ticks_left, 0);
        goto(11); check("phase_c11", phase, 0);
        goto(12); check("phase_c12", phase, 1);
        goto(20); check("phase_c20", phase, 2);
        goto(24); check("phase_c24", phase, 3);
        goto(32); check("phase_c32", phase, 4);
        goto(44); check("phase_c44", phase, 5);
        goto(52); check("phase_c52", phase, 6);
        goto(56); check("phase_c56", phase, 7);
        goto(63); check("phase_c63", phase, 7);
        goto(64); check("phase_wrap_c64", phase, 0);
        check("tl_wrap_c64", ticks_left, 2);

        // Emergency from cycle 1 to 19, then phase 3 interrupted by emergency
        do_reset();
        goto(1);  emergency = 1'b1;
        goto(3);  check("em_phase_c3", phase, 0);
        goto(4);  check("em_short_green", phase, 1);
        check("em_yellow_tl", ticks_left, 1);
        goto(11); check("em_yellow_full", phase, 1);
        goto(12); check("em_phase_c12", phase, 2);
        check("em_red_hold_c12", red_hold, 0);
        goto(13); check("em_red_hold_c13", red_hold, 1);
        goto(20); check("em_red_hold_c20", red_hold, 1);
        check("em_hold_tl", ticks_left, 0);
        emergency = 1'b0;
        goto(21); check("em_red_hold_c21", red_hold, 0);
        goto(23); check("em_hold_c23", phase, 2);
        goto(24); check("em_release_c24", phase, 3);
        check("em_release_tl", ticks_left, 1);
        goto(26); emergency = 1'b1;
        goto(27); check("left_em_pre", phase, 3);
        goto(28); check("left_to_red", phase, 2);
        check("left_to_red_tl", ticks_left, 0);
        goto(29); check("left_red_hold", red_hold, 1);
        goto(32); check("left_hold_c32", phase, 2);
        emergency = 1'b0;
        goto(35); check("left_hold_c35", phase, 2);
        goto(36); check("left_restart", phase, 3);
        check("left_restart_tl", ticks_left, 1);

        // Emergency raised at entry to phase 5 and kept through phase 6
        do_reset();
        goto(44); check("y5_entry", phase, 5);
        emergency = 1'b1;
        goto(48); check("y5_tl_c48", ticks_left, 0);
        goto(51); check("y5_full", phase, 5);
        goto(52); check("y5_to_6", phase, 6);
        goto(53); check("y5_red_hold", red_hold, 1);
        goto(56); check("p6_hold_c56", phase, 6);
        goto(63); check("p6_hold_c63", phase, 6);
        goto(64); emergency = 1'b0;
        goto(67); check("p6_release_c67", phase, 6);
        goto(68); check("p6_to_7", phase, 7);
        check("p6_to_7_tl", ticks_left, 1);

        // Reset pulsed while phase 5 with ticks_left 0
        do_reset();
        goto(49);
        check("pre_rst_phase", phase, 5);
        check("pre_rst_tl", ticks_left, 0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        cyc   = 0;
        check("midrst_phase", phase, 0);
        check("midrst_tl", ticks_left, 2);
        check("midrst_red_hold", red_hold, 0);
        check("midrst_tick", tick, 0);
        goto(3);  check("midrst_tick_c3", tick, 1);
        goto(12); check("midrst_phase_c12", phase, 1);

        // Emergency held from reset onward
        emergency = 1'b1;
        do_reset();
        check("hold_rst_phase", phase, 0);
        goto(3);  check("hold_c3", phase, 0);
        goto(4);  check("hold_c4", phase, 1);
        goto(11); check("hold_c11", phase, 1);
        goto(12); check("hold_c12", phase, 2);
        while (cyc < 100) begin
            next_cycle();
            check("hold_allred", phase, 2);
        end
        check("hold_red_hold", red_hold, 1);
        check("hold_tl", ticks_left, 0);
        emergency = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Timing and state controller for the four-way intersection. It produces the 3-bit phase code that the LED datapath decodes into green/yellow/red/left lamp drives. It generates its own 1-second tick from CLOCK_50 and dwells a parameterised number of ticks in each phase. An emergency input cuts green and left-arrow phases short and holds the intersection all-red until the emergency clears.

## Interface
- CLKS_PER_TICK, 50000000: CLOCK_50 cycles per tick; ≥2.
- GREEN_TICKS, 10: dwell of phases 0 and 4; 1..255.
- YELLOW_TICKS, 3: dwell of phases 1 and 5; 1..255.
- ALLRED_TICKS, 2: dwell of phases 2 and 6; 1..255.
- LEFT_TICKS, 5: dwell of phases 3 and 7; 1..255.

- CLOCK_50  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- emergency  in  1  level; sampled every cycle.
- phase  out  3  phase code to the LED datapath, registered.
- tick  out  1  one-cycle pulse, high when the prescaler equals CLKS_PER_TICK-1.
- ticks_left  out  8  registered dwell counter; 0 means the current phase ends on the next tick.
- red_hold  out  1  registered; high while the phase is frozen all-red by emergency.

## Operation
- Phase codes: 0 NS green, 1 NS yellow, 2 all-red, 3 EW left, 4 EW green, 5 EW yellow, 6 all-red, 7 NS left.
- Normal sequence: 0→1→2→3→4→5→6→7→0, wrapping from 7 to 0.
- Prescaler: counts 0..CLKS_PER_TICK-1 and wraps to 0. Width is ceil(log2(CLKS_PER_TICK)).
- Dwell: on entry to a phase, ticks_left loads that phase's dwell minus 1. Each tick decrements it. On a tick with ticks_left==0, the phase advances. No decrement wraps below 0.
- Emergency is evaluated only on tick cycles:
  - Phase 0 or 4 with emergency=1: advance to 1 or 5 immediately, regardless of ticks_left. Yellow is never shortened.
  - Phase 3 with emergency=1: go to 2. Phase 7 with emergency=1: go to 6. The left phase restarts after release.
  - Phase 2 or 6 with emergency=1: stay in the phase, with ticks_left held at ALLRED_TICKS-1 on every tick.
  - Phase 1 or 5: normal behaviour; the emergency takes effect on arrival in 2 or 6.
- Release: once emergency=0, the all-red phase counts down normally from ALLRED_TICKS-1 and advances on the ALLRED_TICKS-th tick after release.
- red_hold: next cycle equals (phase∈{2,6} && emergency). It is cleared by reset.
- Reset values: phase=0, prescaler=0, ticks_left=GREEN_TICKS-1, red_hold=0. tick=0 because the prescaler is 0.

## Timing
- tick is combinational from the prescaler. phase and ticks_left update on the edge ending the tick cycle, so new values are visible one cycle after tick.
- Each phase lasts exactly dwell×CLKS_PER_TICK cycles. The first phase after reset is included, since the prescaler restarts at 0.
- Emergency changes between ticks have no effect on phase until the next tick. Only red_hold reacts within one cycle.
- Reset asserted mid-phase: all registers take their reset values on the next edge. emergency is ignored while reset=1.
- Emergency and ticks_left==0 on the same tick in phase 0/4: the result is the same single advance to yellow.
- Emergency and ticks_left==0 on the same tick in phase 2/6: emergency wins and the phase holds.

## Test plan
Bench parameters: CLKS_PER_TICK=4, GREEN=3, YELLOW=2, ALLRED=1, LEFT=2. Reset is released before cycle 0.
- Free run, emergency=0:
  - tick is high at cycles 3, 7, 11, ….
  - phase=0 for cycles 0–11, then 1 at cycle 12, 2 at cycle 20, 3 at cycle 24, 4 at cycle 32.
  - phase returns to 0 at cycle 64.
  - ticks_left in phase 0 reads 2, 1, 0.
- Emergency raised at cycle 1 and dropped at cycle 20:
  - phase=1 at cycle 4 and phase=2 at cycle 12.
  - red_hold=1 for cycles 13–20.
  - phase stays 2 through cycle 23, then becomes 3 at cycle 24.
- Emergency high during phase 3 on a tick: phase goes 3→2 on the next cycle and holds. After release, phase goes 2→3 again with ticks_left=1.
- Emergency high only during phase 5: yellow completes its full 2 ticks, then the block holds in phase 6 with red_hold=1.
- Reset pulsed for one cycle while phase=5 and ticks_left=0: the next cycle shows phase=0, ticks_left=2, red_hold=0, tick=0. The normal sequence then resumes from cycle 0.
- Emergency held high continuously from reset: the sequence is 0 (1 tick), 1 (2 ticks), then phase 2 held indefinitely. Phase never reaches 3.
